// File: rtl/temp_seg_scan.sv
// DS18B20 temperature word -> signed decimal (one fractional digit), scanned onto six 7-seg digits.
// Build macro SEG_LZB_EN enables leading-zero blanking of the hundreds and tens digits.
module temp_seg_scan #(
  parameter int SCAN_DIV = 50_000,
  parameter int N_DIG    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] temp_raw,
  input  logic        temp_vld,
  output logic        busy,
  output logic [15:0] Data,
  output logic        S_EN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [18:0] dd_reg;
  logic [18:0] dd_adj;
  logic [2:0]  step_reg;
  logic        neg_reg;
  logic        err_reg;
  logic [3:0]  tenths_reg;
  logic [7:0]  disp_reg [N_DIG];
  logic [7:0]  disp_next [N_DIG];

  logic [15:0] mag;
  logic [3:0]  tenths_next;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;

  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [2:0]       idx_next;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign mag         = temp_raw[15] ? -temp_raw : temp_raw;
  assign tenths_next = 4'(({4'd0, mag[3:0]} * 8'd10) >> 4);

  // dd_reg = {hundreds, tens, ones, binary}; each BCD nibble >= 5 gets +3 before the shift
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign dd_adj[7+4*gi +: 4] = (dd_reg[7+4*gi +: 4] >= 4'd5) ? dd_reg[7+4*gi +: 4] + 4'd3
                                                                 : dd_reg[7+4*gi +: 4];
  end
  assign dd_adj[6:0] = dd_reg[6:0];

  assign hund = dd_reg[18:15];
  assign tens = dd_reg[14:11];
  assign ones = dd_reg[10:7];

  always_comb begin
    for (int i = 0; i < N_DIG; i++) begin
      disp_next[i] = SEG_BLANK;
    end
    if (err_reg) begin
      disp_next[4] = SEG_E;
      disp_next[3] = SEG_R;
      disp_next[2] = SEG_R;
    end else begin
      disp_next[5] = neg_reg ? SEG_MINUS : SEG_BLANK;
      disp_next[4] = seg_code(hund);
      disp_next[3] = seg_code(tens);
`ifdef SEG_LZB_EN
      if (hund == 4'd0) begin
        disp_next[4] = SEG_BLANK;
        if (tens == 4'd0) begin
          disp_next[3] = SEG_BLANK;
        end
      end
`endif
      disp_next[2] = seg_code(ones) & 8'h7F;
      disp_next[1] = seg_code(tenths_reg);
      disp_next[0] = SEG_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      dd_reg     <= '0;
      step_reg   <= '0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
      tenths_reg <= '0;
      for (int i = 0; i < N_DIG; i++) begin
        disp_reg[i] <= SEG_BLANK;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (temp_vld) begin
            neg_reg    <= temp_raw[15];
            err_reg    <= |mag[15:11];
            tenths_reg <= tenths_next;
            dd_reg     <= {12'd0, mag[10:4]};
            step_reg   <= '0;
            busy       <= 1'b1;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          dd_reg   <= dd_adj << 1;
          step_reg <= step_reg + 3'd1;
          if (step_reg == 3'd6) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // all six digits change together so a scan never mixes old and new readings
          disp_reg  <= disp_next;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign idx_next = (idx_reg == 3'(N_DIG - 1)) ? 3'd0 : idx_reg + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      Data    <= 16'hFFFF;
      S_EN    <= 1'b0;
    end else begin
      S_EN <= 1'b0;
      if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
        cnt_reg <= '0;
        idx_reg <= idx_next;
        Data    <= {disp_reg[idx_next], ~(8'b1 << idx_next)};
        S_EN    <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule
